gtfwizard_0_example_gtfmac_hwchk_bitslip_seq: RTL and testbench

GTFWIZARD_0_EXAMPLE_GTFMAC_HWCHK_BITSLIP_SEQ -- requirements
Module: gtfwizard_0_example_gtfmac_hwchk_bitslip_seq

---
 rtl/gtfwizard_0_example_gtfmac_hwchk_bitslip_seq.sv | 183 ++++++++++++++++++
 tb/tb_gtfwizard_0_example_gtfmac_hwchk_bitslip_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtfwizard_0_example_gtfmac_hwchk_bitslip_seq.sv
// Bitslip bring-up sequencer: resets the adjuster, waits for a stable lock, requests correction.
// Define BITSLIP_SEQ_AUTO_RELOCK_EN to restart the sequence automatically on lock loss in DONE.
module gtfwizard_0_example_gtfmac_hwchk_bitslip_seq #(
    parameter int unsigned RST_CYC         = 16,
    parameter int unsigned LOCK_STABLE_CYC = 256,
    parameter int unsigned LOCK_TIMEOUT    = 65536,
    parameter int unsigned MAX_RETRY       = 7
) (
    input  logic       rx_clk,
    input  logic       rx_rst_n,
    input  logic       ctl_start,
    input  logic       ctl_rx_data_rate,
    input  logic       stat_locked,
    input  logic       stat_done,
    input  logic       stat_excessive_bitslip,
    output logic       bs_rst,
    output logic       bs_correct_bitslip,
    output logic [2:0] seq_state,
    output logic [2:0] stat_retry_cnt,
    output logic       stat_timeout,
    output logic       stat_lock_lost,
    output logic       stat_seq_done,
    output logic       stat_seq_fail
);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StReset      = 3'd1,
        StWaitLock   = 3'd2,
        StLockStable = 3'd3,
        StCorrect    = 3'd4,
        StVerify     = 3'd5,
        StDone       = 3'd6,
        StFail       = 3'd7
    } state_e;

    localparam int unsigned CntMax = (LOCK_TIMEOUT > RST_CYC) ? LOCK_TIMEOUT : RST_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned StabW  = $clog2(LOCK_STABLE_CYC + 1);

    localparam logic [CntW-1:0]  RstLast   = CntW'(RST_CYC - 1);
    localparam logic [CntW-1:0]  ToLast    = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [StabW-1:0] StabLast  = StabW'(LOCK_STABLE_CYC - 1);
    localparam logic [2:0]       RetryLast = 3'(MAX_RETRY - 1);

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [StabW-1:0]  stab_q;
    logic              start_q;

    logic start_rise;
    logic in_wait;
    logic timeout;
    logic stable;
    logic success;
    logic failure;

    assign start_rise = ctl_start & ~start_q;
    assign in_wait    = state_q inside {StWaitLock, StLockStable, StCorrect, StVerify};
    assign timeout    = in_wait & (cnt_q == ToLast);
    assign stable     = stat_locked & (stab_q == StabLast);
    assign seq_state  = state_q;

    always_comb begin
        success = 1'b0;
        case (state_q)
            StWaitLock:             success = stat_locked;
            StLockStable, StVerify: success = stable;
            StCorrect:              success = stat_done;
            default:                success = 1'b0;
        endcase
    end

    // A success event outranks a coincident timeout; excessive bitslip always fails.
    assign failure = in_wait & (stat_excessive_bitslip | (timeout & ~success));

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q            <= StIdle;
            cnt_q              <= '0;
            stab_q             <= '0;
            // Reset high so a start held across reset release is not seen as an edge.
            start_q            <= 1'b1;
            bs_rst             <= 1'b1;
            bs_correct_bitslip <= 1'b0;
            stat_retry_cnt     <= '0;
            stat_timeout       <= 1'b0;
            stat_lock_lost     <= 1'b0;
            stat_seq_done      <= 1'b0;
            stat_seq_fail      <= 1'b0;
        end else begin
            start_q <= ctl_start;
            cnt_q   <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            stab_q  <= stat_locked ? ((stab_q == '1) ? stab_q : stab_q + 1'b1) : '0;

            if (start_rise && (state_q inside {StIdle, StDone, StFail})) begin
                stat_retry_cnt     <= '0;
                stat_timeout       <= 1'b0;
                stat_lock_lost     <= 1'b0;
                stat_seq_done      <= 1'b0;
                stat_seq_fail      <= 1'b0;
                state_q            <= StReset;
                cnt_q              <= '0;
                bs_rst             <= 1'b1;
                bs_correct_bitslip <= 1'b0;
            end else if (failure) begin
                if (timeout && !success) begin
                    stat_timeout <= 1'b1;
                end
                cnt_q              <= '0;
                bs_rst             <= 1'b1;
                bs_correct_bitslip <= 1'b0;
                if (stat_retry_cnt < RetryLast) begin
                    stat_retry_cnt <= stat_retry_cnt + 3'd1;
                    state_q        <= StReset;
                end else begin
                    stat_seq_fail  <= 1'b1;
                    state_q        <= StFail;
                end
            end else begin
                unique case (state_q)
                    StReset: begin
                        if (cnt_q == RstLast) begin
                            state_q <= StWaitLock;
                            cnt_q   <= '0;
                            bs_rst  <= 1'b0;
                        end
                    end
                    StWaitLock: begin
                        if (stat_locked) begin
                            state_q <= StLockStable;
                            cnt_q   <= '0;
                            stab_q  <= '0;
                        end
                    end
                    StLockStable: begin
                        if (stable) begin
                            cnt_q <= '0;
                            if (ctl_rx_data_rate) begin
                                state_q       <= StDone;
                                stat_seq_done <= 1'b1;
                            end else begin
                                state_q            <= StCorrect;
                                bs_correct_bitslip <= 1'b1;
                            end
                        end
                    end
                    StCorrect: begin
                        if (stat_done) begin
                            state_q            <= StVerify;
                            cnt_q              <= '0;
                            stab_q             <= '0;
                            bs_correct_bitslip <= 1'b0;
                        end
                    end
                    StVerify: begin
                        if (stable) begin
                            state_q       <= StDone;
                            cnt_q         <= '0;
                            stat_seq_done <= 1'b1;
                        end
                    end
                    StDone: begin
                        if (!stat_locked) begin
                            stat_lock_lost <= 1'b1;
`ifdef BITSLIP_SEQ_AUTO_RELOCK_EN
                            stat_retry_cnt <= '0;
                            stat_seq_done  <= 1'b0;
                            state_q        <= StReset;
                            cnt_q          <= '0;
                            bs_rst         <= 1'b1;
`else
                            state_q        <= StDone;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtfwizard_0_example_gtfmac_hwchk_bitslip_seq.sv
// Directed bench for the bitslip sequencer; one task per scenario, hand-computed expectations.
module tb_gtfwizard_0_example_gtfmac_hwchk_bitslip_seq;

    logic       rx_clk = 1'b0;
    logic       rx_rst_n = 1'b0;
    logic       ctl_start = 1'b0;
    logic       ctl_rx_data_rate = 1'b0;
    logic       stat_locked = 1'b0;
    logic       stat_done = 1'b0;
    logic       stat_excessive_bitslip = 1'b0;
    logic       bs_rst;
    logic       bs_correct_bitslip;
    logic [2:0] seq_state;
    logic [2:0] stat_retry_cnt;
    logic       stat_timeout;
    logic       stat_lock_lost;
    logic       stat_seq_done;
    logic       stat_seq_fail;

    int checks = 0;
    int errors = 0;

    gtfwizard_0_example_gtfmac_hwchk_bitslip_seq #(
        .RST_CYC         (16),
        .LOCK_STABLE_CYC (8),
        .LOCK_TIMEOUT    (100),
        .MAX_RETRY       (3)
    ) dut (
        .rx_clk                 (rx_clk),
        .rx_rst_n               (rx_rst_n),
        .ctl_start              (ctl_start),
        .ctl_rx_data_rate       (ctl_rx_data_rate),
        .stat_locked            (stat_locked),
        .stat_done              (stat_done),
        .stat_excessive_bitslip (stat_excessive_bitslip),
        .bs_rst                 (bs_rst),
        .bs_correct_bitslip     (bs_correct_bitslip),
        .seq_state              (seq_state),
        .stat_retry_cnt         (stat_retry_cnt),
        .stat_timeout           (stat_timeout),
        .stat_lock_lost         (stat_lock_lost),
        .stat_seq_done          (stat_seq_done),
        .stat_seq_fail          (stat_seq_fail)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic step();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output int n);
        n = 0;
        while (seq_state !== s && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_start();
        ctl_start = 1'b0;
        step();
        ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] stats;
        rx_rst_n = 1'b0;
        repeat (3) step();
        stats = {stat_retry_cnt, stat_timeout, stat_lock_lost, stat_seq_done, stat_seq_fail};
        checks++;
        if (seq_state !== 3'd0 || bs_rst !== 1'b1 || bs_correct_bitslip !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: state=%0d bs_rst=%b corr=%b, expected 0/1/0",
                     seq_state, bs_rst, bs_correct_bitslip);
        end
        checks++;
        if (stats !== 7'd0) begin
            errors++;
            $display("FAIL reset_stats: got %b expected 0000000", stats);
        end
        #2 rx_rst_n = 1'b1;
        repeat (5) step();
        checks++;
        if (seq_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d expected 0", seq_state);
        end
    endtask

    task automatic test_nominal_10g();
        int n;
        int bad;
        ctl_rx_data_rate = 1'b0;
        stat_locked = 1'b0;
        ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
        checks++;
        if (seq_state !== 3'd1 || bs_rst !== 1'b1) begin
            errors++;
            $display("FAIL nom_start: state=%0d bs_rst=%b expected 1/1", seq_state, bs_rst);
        end
        n = 0;
        bad = 0;
        while (seq_state === 3'd1 && n < 40) begin
            if (bs_rst !== 1'b1) bad++;
            n++;
            step();
        end
        checks++;
        if (n != 16 || bad != 0) begin
            errors++;
            $display("FAIL nom_rst_len: reset cycles=%0d low=%0d expected 16/0", n, bad);
        end
        checks++;
        if (seq_state !== 3'd2 || bs_rst !== 1'b0) begin
            errors++;
            $display("FAIL nom_wait_lock: state=%0d bs_rst=%b expected 2/0", seq_state, bs_rst);
        end
        repeat (4) step();
        stat_locked = 1'b1;
        step();
        n = 0;
        while (seq_state === 3'd3 && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n != 8 || seq_state !== 3'd4 || bs_correct_bitslip !== 1'b1) begin
            errors++;
            $display("FAIL nom_stable: cycles=%0d state=%0d corr=%b expected 8/4/1",
                     n, seq_state, bs_correct_bitslip);
        end
        bad = 0;
        repeat (20) begin
            if (bs_correct_bitslip !== 1'b1 || seq_state !== 3'd4) bad++;
            step();
        end
        stat_done = 1'b1;
        step();
        stat_done = 1'b0;
        checks++;
        if (bad != 0 || seq_state !== 3'd5 || bs_correct_bitslip !== 1'b0) begin
            errors++;
            $display("FAIL nom_correct: bad=%0d state=%0d corr=%b expected 0/5/0",
                     bad, seq_state, bs_correct_bitslip);
        end
        n = 0;
        while (seq_state === 3'd5 && n < 40) begin
            n++;
            step();
        end
        checks++;
        if (n != 8 || seq_state !== 3'd6) begin
            errors++;
            $display("FAIL nom_verify: cycles=%0d state=%0d expected 8/6", n, seq_state);
        end
        checks++;
        if (stat_seq_done !== 1'b1 || stat_retry_cnt !== 3'd0 || stat_timeout !== 1'b0) begin
            errors++;
            $display("FAIL nom_done: done=%b retry=%0d to=%b expected 1/0/0",
                     stat_seq_done, stat_retry_cnt, stat_timeout);
        end
    endtask

    task automatic test_25g();
        int n;
        int n3;
        logic ever_corr;
        ctl_rx_data_rate = 1'b1;
        stat_locked = 1'b1;
        ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
        checks++;
        if (seq_state !== 3'd1 || stat_seq_done !== 1'b0) begin
            errors++;
            $display("FAIL g25_restart: state=%0d done=%b expected 1/0", seq_state, stat_seq_done);
        end
        n = 0;
        n3 = 0;
        ever_corr = 1'b0;
        while (seq_state !== 3'd6 && n < 200) begin
            if (seq_state === 3'd3) n3++;
            ever_corr = ever_corr | bs_correct_bitslip;
            step();
            n++;
        end
        checks++;
        if (seq_state !== 3'd6 || n3 != 8 || ever_corr !== 1'b0 || stat_seq_done !== 1'b1) begin
            errors++;
            $display("FAIL g25_done: state=%0d stable=%0d corr=%b done=%b expected 6/8/0/1",
                     seq_state, n3, ever_corr, stat_seq_done);
        end
    endtask

    task automatic test_lock_glitch();
        int n;
        ctl_rx_data_rate = 1'b0;
        stat_locked = 1'b0;
        pulse_start();
        wait_state(3'd2, 50, n);
        stat_locked = 1'b1;
        step();
        repeat (5) step();
        stat_locked = 1'b0;
        step();
        checks++;
        if (seq_state !== 3'd3) begin
            errors++;
            $display("FAIL glitch_hold: state=%0d expected 3", seq_state);
        end
        stat_locked = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (seq_state === 3'd3 && n < 30);
        checks++;
        if (n != 8 || seq_state !== 3'd4) begin
            errors++;
            $display("FAIL glitch_restable: cycles=%0d state=%0d expected 8/4", n, seq_state);
        end
    endtask

    task automatic test_reset_mid_correct();
        repeat (3) step();
        checks++;
        if (seq_state !== 3'd4 || bs_correct_bitslip !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: state=%0d corr=%b expected 4/1", seq_state, bs_correct_bitslip);
        end
        ctl_start = 1'b1;
        #2 rx_rst_n = 1'b0;
        #1;
        checks++;
        if (bs_correct_bitslip !== 1'b0 || seq_state !== 3'd0 || bs_rst !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async: corr=%b state=%0d bs_rst=%b expected 0/0/1",
                     bs_correct_bitslip, seq_state, bs_rst);
        end
        #2 rx_rst_n = 1'b1;
        repeat (5) step();
        checks++;
        if (seq_state !== 3'd0) begin
            errors++;
            $display("FAIL midrst_no_restart: state=%0d expected 0", seq_state);
        end
        ctl_start = 1'b0;
        step();
    endtask

    task automatic test_no_lock();
        int n;
        stat_locked = 1'b0;
        ctl_rx_data_rate = 1'b0;
        ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
        wait_state(3'd7, 1000, n);
        checks++;
        if (n != 348 || seq_state !== 3'd7) begin
            errors++;
            $display("FAIL nolock_len: cycles=%0d state=%0d expected 348/7", n, seq_state);
        end
        checks++;
        if (stat_timeout !== 1'b1 || stat_retry_cnt !== 3'd2 || stat_seq_fail !== 1'b1 ||
            bs_rst !== 1'b1 || bs_correct_bitslip !== 1'b0) begin
            errors++;
            $display("FAIL nolock_status: to=%b retry=%0d fail=%b bs_rst=%b corr=%b exp 1/2/1/1/0",
                     stat_timeout, stat_retry_cnt, stat_seq_fail, bs_rst, bs_correct_bitslip);
        end
    endtask

    task automatic test_excessive();
        int n;
        pulse_start();
        checks++;
        if (stat_timeout !== 1'b0 || stat_seq_fail !== 1'b0 || stat_retry_cnt !== 3'd0) begin
            errors++;
            $display("FAIL exc_clear: to=%b fail=%b retry=%0d expected 0/0/0",
                     stat_timeout, stat_seq_fail, stat_retry_cnt);
        end
        wait_state(3'd2, 50, n);
        stat_excessive_bitslip = 1'b1;
        step();
        stat_excessive_bitslip = 1'b0;
        checks++;
        if (seq_state !== 3'd1 || stat_retry_cnt !== 3'd1 || stat_timeout !== 1'b0 ||
            bs_rst !== 1'b1) begin
            errors++;
            $display("FAIL exc_retry: state=%0d retry=%0d to=%b bs_rst=%b expected 1/1/0/1",
                     seq_state, stat_retry_cnt, stat_timeout, bs_rst);
        end
    endtask

    task automatic test_timeout_vs_lock();
        int n;
        wait_state(3'd2, 50, n);
        repeat (99) step();
        checks++;
        if (seq_state !== 3'd2) begin
            errors++;
            $display("FAIL tovl_pre: state=%0d expected 2", seq_state);
        end
        stat_locked = 1'b1;
        step();
        checks++;
        if (seq_state !== 3'd3 || stat_retry_cnt !== 3'd1 || stat_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tovl_success: state=%0d retry=%0d to=%b expected 3/1/0",
                     seq_state, stat_retry_cnt, stat_timeout);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        ctl_rx_data_rate = 1'b1;
        wait_state(3'd6, 50, n);
        checks++;
        if (seq_state !== 3'd6 || stat_seq_done !== 1'b1 || stat_lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL loss_pre: state=%0d done=%b lost=%b expected 6/1/0",
                     seq_state, stat_seq_done, stat_lock_lost);
        end
        stat_locked = 1'b0;
        step();
        stat_locked = 1'b1;
`ifdef BITSLIP_SEQ_AUTO_RELOCK_EN
        checks++;
        if (stat_lock_lost !== 1'b1 || seq_state !== 3'd1 || stat_seq_done !== 1'b0 ||
            stat_retry_cnt !== 3'd0) begin
            errors++;
            $display("FAIL loss_relock: lost=%b state=%0d done=%b retry=%0d expected 1/1/0/0",
                     stat_lock_lost, seq_state, stat_seq_done, stat_retry_cnt);
        end
`else
        checks++;
        if (stat_lock_lost !== 1'b1 || seq_state !== 3'd6 || stat_seq_done !== 1'b1) begin
            errors++;
            $display("FAIL loss_stay: lost=%b state=%0d done=%b expected 1/6/1",
                     stat_lock_lost, seq_state, stat_seq_done);
        end
`endif
        repeat (3) step();
        checks++;
        if (stat_lock_lost !== 1'b1) begin
            errors++;
            $display("FAIL loss_sticky: lost=%b expected 1", stat_lock_lost);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal_10g();
        test_25g();
        test_lock_glitch();
        test_reset_mid_correct();
        test_no_lock();
        test_excessive();
        test_timeout_vs_lock();
        test_lock_loss();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
